// File: rtl/i2c_arbiter.sv
// Two-client round-robin arbiter in front of a single I2C byte master.
// It latches the winning client's command, issues a one-cycle exec and tracks
// the transfer. After a write it holds an idle gap so the EEPROM can finish its
// internal write cycle. A watchdog aborts a transfer whose i2c_done never comes.
module i2c_arbiter #(
  parameter int unsigned WR_GAP_CYC  = 250_000,
  parameter int unsigned TIMEOUT_CYC = 4_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        addr_hl0,
  input  logic        addr_hl1,
  input  logic [15:0] word_addr0,
  input  logic [15:0] word_addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        exec,
  output logic        we_o,
  output logic        addr_hl,
  output logic [15:0] word_addr,
  output logic [7:0]  wdata,
  input  logic        i2c_done,
  input  logic [7:0]  rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;
  localparam bit          GAP_EN  = (WR_GAP_CYC != 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(WR_GAP_CYC);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;    // client served most recently
  logic             owner_q, owner_d;  // client owning the transfer in flight
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] gap_q, gap_d;

  logic          gnt0_d, gnt1_d, done0_d, done1_d, err0_d, err1_d, exec_d, busy_d;
  logic [DW-1:0] rdata0_d, rdata1_d, wdata_d;
  logic          we_d, addr_hl_d;
  logic [AW-1:0] word_addr_d;
  logic          win;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    exec_d      = 1'b0;
    rdata0_d    = rdata0;
    rdata1_d    = rdata1;
    we_d        = we_o;
    addr_hl_d   = addr_hl;
    word_addr_d = word_addr;
    wdata_d     = wdata;
    win         = (req0 && req1) ? ~last_q : req1;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d     = win;
          gnt0_d      = ~win;
          gnt1_d      = win;
          we_d        = win ? we1        : we0;
          addr_hl_d   = win ? addr_hl1   : addr_hl0;
          word_addr_d = win ? word_addr1 : word_addr0;
          wdata_d     = win ? wdata1     : wdata0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        exec_d  = 1'b1;
        timer_d = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        timer_d = timer_q + CNT_W'(1);
        if (i2c_done) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          if (!we_o) begin
            if (owner_q) rdata1_d = rdata;
            else         rdata0_d = rdata;
          end
          last_d = owner_q;
          if (we_o && GAP_EN) begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timer_q == TO_LAST) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          err0_d  = ~owner_q;
          err1_d  = owner_q;
          last_d  = owner_q;
          if (GAP_EN) begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - CNT_W'(1);
        if (gap_q <= CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      timer_q   <= '0;
      gap_q     <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      exec      <= 1'b0;
      busy      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      we_o      <= 1'b0;
      addr_hl   <= 1'b0;
      word_addr <= '0;
      wdata     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      done0     <= done0_d;
      done1     <= done1_d;
      err0      <= err0_d;
      err1      <= err1_d;
      exec      <= exec_d;
      busy      <= busy_d;
      rdata0    <= rdata0_d;
      rdata1    <= rdata1_d;
      we_o      <= we_d;
      addr_hl   <= addr_hl_d;
      word_addr <= word_addr_d;
      wdata     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a scoreboard of expected grants and completions.
module tb_i2c_arbiter;

  localparam int unsigned GAP = 10;
  localparam int unsigned TO  = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, addr_hl0, addr_hl1;
  logic [15:0] word_addr0, word_addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [7:0]  rdata0, rdata1;
  logic        exec, we_o, addr_hl;
  logic [15:0] word_addr;
  logic [7:0]  wdata;
  logic        i2c_done;
  logic [7:0]  rdata;
  logic        busy;

  typedef struct {
    int         client;
    bit         err;
    logic [7:0] rd;
  } done_t;

  int    exp_gnt[$];
  done_t exp_done[$];
  int    n_cmp = 0;
  int    n_mis = 0;

  i2c_arbiter #(.WR_GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr_hl0(addr_hl0), .addr_hl1(addr_hl1),
    .word_addr0(word_addr0), .word_addr1(word_addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .exec(exec), .we_o(we_o), .addr_hl(addr_hl), .word_addr(word_addr),
    .wdata(wdata), .i2c_done(i2c_done), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard whenever the DUT pulses a grant or a completion
  task automatic check_outputs();
    int    g;
    done_t d;
    if (gnt0 || gnt1) begin
      if (exp_gnt.size() == 0) chk("gnt_unexpected", {30'd0, gnt1, gnt0}, 32'd0);
      else begin
        g = exp_gnt.pop_front();
        chk("gnt", {30'd0, gnt1, gnt0}, (g == 0) ? 32'd1 : 32'd2);
      end
    end
    if (done0 || done1) begin
      if (exp_done.size() == 0) chk("done_unexpected", {30'd0, done1, done0}, 32'd0);
      else begin
        d = exp_done.pop_front();
        chk("done", {30'd0, done1, done0}, (d.client == 0) ? 32'd1 : 32'd2);
        chk("err", {30'd0, err1, err0},
            d.err ? ((d.client == 0) ? 32'd1 : 32'd2) : 32'd0);
        chk("rdata", {24'd0, (d.client == 0) ? rdata0 : rdata1}, {24'd0, d.rd});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic push_done(input int c, input bit e, input logic [7:0] r);
    done_t d;
    d.client = c;
    d.err    = e;
    d.rd     = r;
    exp_done.push_back(d);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {gnt0, gnt1, done0, done1, err0, err1, exec, we_o, addr_hl, busy,
              rdata0, rdata1, 6'd0}, 32'd0);
    chk({tag, "_bus"}, {word_addr, wdata, 8'd0}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr_hl0 = 0; addr_hl1 = 0;
    word_addr0 = '0; word_addr1 = '0; wdata0 = '0; wdata1 = '0;
    i2c_done = 0; rdata = '0;
    #1;
    check_all_zero("reset_state");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: read by client 0, answered after 5 cycles
    req0 = 1; we0 = 0; addr_hl0 = 1; word_addr0 = 16'h0000;
    exp_gnt.push_back(0);
    tick();
    chk("t1_gnt0", {31'd0, gnt0}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    req0 = 0;
    tick();
    chk("t1_exec", {31'd0, exec}, 32'd1);
    chk("t1_gnt_gone", {31'd0, gnt0}, 32'd0);
    repeat (4) tick();
    i2c_done = 1; rdata = 8'hAB;
    push_done(0, 0, 8'hAB);
    tick();
    i2c_done = 0; rdata = 8'h00;
    chk("t1_done0", {31'd0, done0}, 32'd1);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // 2: write by client 0, post-write gap
    req0 = 1; we0 = 1; addr_hl0 = 0; word_addr0 = 16'h0012; wdata0 = 8'h5A;
    exp_gnt.push_back(0);
    tick();
    req0 = 0;
    chk("t2_bus", {we_o, addr_hl, word_addr, wdata, 6'd0}, {1'b1, 1'b0, 16'h0012, 8'h5A, 6'd0});
    wdata0 = 8'hFF; word_addr0 = 16'h7777;
    tick();
    chk("t2_exec", {31'd0, exec}, 32'd1);
    chk("t2_latched", {8'd0, word_addr, wdata}, {8'd0, 16'h0012, 8'h5A});
    repeat (3) tick();
    i2c_done = 1; rdata = 8'hEE;
    push_done(0, 0, 8'hAB);
    tick();
    i2c_done = 0;
    req0 = 1; we0 = 0;
    for (int i = 0; i < int'(GAP); i++) begin
      chk($sformatf("t2_gap_busy%0d", i), {31'd0, busy}, 32'd1);
      tick();
    end
    chk("t2_gap_end", {30'd0, busy, gnt0}, 32'd0);
    exp_gnt.push_back(0);
    tick();
    req0 = 0;
    tick();
    i2c_done = 1; rdata = 8'h11;
    push_done(0, 0, 8'h11);
    tick();
    i2c_done = 0;

    // 3: both clients held from reset -> 0,1,0,1
    rst_n = 0; tick(); rst_n = 1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    for (int k = 0; k < 4; k++) begin
      exp_gnt.push_back(k % 2);
      tick();
      tick();
      chk($sformatf("t3_exec%0d", k), {31'd0, exec}, 32'd1);
      tick();
      i2c_done = 1; rdata = 8'(8'h30 + k);
      push_done(k % 2, 0, 8'(8'h30 + k));
      tick();
      i2c_done = 0;
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
    end
    chk("t3_rdata0", {24'd0, rdata0}, 32'h32);

    // 4: client 1 read never answered -> timeout abort
    req1 = 1; we1 = 0;
    exp_gnt.push_back(1);
    tick();
    req1 = 0;
    tick();
    chk("t4_exec", {31'd0, exec}, 32'd1);
    repeat (int'(TO) - 1) tick();
    push_done(1, 1, 8'h33);
    tick();
    chk("t4_err1", {31'd0, err1}, 32'd1);
    for (int i = 0; i < int'(GAP); i++) tick();
    chk("t4_gap_busy_last", {31'd0, busy}, 32'd0);

    // 5: i2c_done on the timeout terminal cycle wins
    req0 = 1; we0 = 0;
    exp_gnt.push_back(0);
    tick();
    req0 = 0;
    tick();
    repeat (int'(TO) - 1) tick();
    i2c_done = 1; rdata = 8'h77;
    push_done(0, 0, 8'h77);
    tick();
    i2c_done = 0;
    chk("t5_no_err", {30'd0, err1, err0}, 32'd0);
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // 6: reset mid-transfer, stray i2c_done, post-reset tie
    req1 = 1; we1 = 1; word_addr1 = 16'hBEEF; wdata1 = 8'hC3;
    exp_gnt.push_back(1);
    tick();
    req1 = 0;
    tick(); tick();
    #2 rst_n = 0;
    #1;
    check_all_zero("t6_async_reset");
    tick();
    rst_n = 1;
    i2c_done = 1; rdata = 8'h55;
    tick();
    i2c_done = 0;
    chk("t6_stray_done", {29'd0, done0, done1, busy}, 32'd0);
    req0 = 1; req1 = 1; we0 = 0;
    exp_gnt.push_back(0);
    tick();
    req0 = 0; req1 = 0;
    tick();
    i2c_done = 1; rdata = 8'h99;
    push_done(0, 0, 8'h99);
    tick();
    i2c_done = 0;
    tick();

    chk("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
